// File: rtl/gray_seg_decoder.sv
// Gray-code switch value to one 7-segment digit (units or tens), two register stages.
// Latency 2 cycles, one sample per cycle, no handshake.
module gray_seg_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_code,
  input  logic       show_decades,
  output logic [6:0] display_code
);

  logic [3:0] gray_q;
  logic       sel_q;
  logic [3:0] bin;
  logic [3:0] digit;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= 4'd0;
      sel_q  <= 1'b0;
    end else begin
      gray_q <= gray_code;
      sel_q  <= show_decades;
    end
  end

  assign bin[3] = gray_q[3];
  assign bin[2] = gray_q[3] ^ gray_q[2];
  assign bin[1] = gray_q[3] ^ gray_q[2] ^ gray_q[1];
  assign bin[0] = ^gray_q;

  always_comb begin
    digit = 4'd0;
    if (sel_q) begin
      digit = (bin >= 4'd10) ? 4'd1 : 4'd0;
    end else begin
      digit = (bin >= 4'd10) ? (bin - 4'd10) : bin;
    end
  end

  // Patterns held active-high {g,f,e,d,c,b,a}; all-zero means dark.
  always_comb begin
    seg_d = 7'b0000000;
    case (digit)
      4'd0:    seg_d = 7'b0111111;
      4'd1:    seg_d = 7'b0000110;
      4'd2:    seg_d = 7'b1011011;
      4'd3:    seg_d = 7'b1001111;
      4'd4:    seg_d = 7'b1100110;
      4'd5:    seg_d = 7'b1101101;
      4'd6:    seg_d = 7'b1111101;
      4'd7:    seg_d = 7'b0000111;
      4'd8:    seg_d = 7'b1111111;
      4'd9:    seg_d = 7'b1101111;
      default: seg_d = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'b0000000;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign display_code = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_gray_seg_decoder.sv
// Bench for gray_seg_decoder: both polarities driven in parallel, expected codes queued per sample.
module tb_gray_seg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] gray_code = 4'd0;
  logic       show_decades = 1'b0;
  logic [6:0] disp_lo;
  logic [6:0] disp_hi;

  typedef struct {
    logic [3:0] g;
    logic       s;
    logic [6:0] lo;
    logic [6:0] hi;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  gray_seg_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .gray_code(gray_code),
    .show_decades(show_decades), .display_code(disp_lo)
  );

  gray_seg_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .gray_code(gray_code),
    .show_decades(show_decades), .display_code(disp_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] g, input logic s);
    logic [3:0] v;
    int d;
    v = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    if (s) d = (v >= 4'd10) ? 1 : 0;
    else   d = int'(v) % 10;
    case (d)
      0: pat = 7'b0111111;
      1: pat = 7'b0000110;
      2: pat = 7'b1011011;
      3: pat = 7'b1001111;
      4: pat = 7'b1100110;
      5: pat = 7'b1101101;
      6: pat = 7'b1111101;
      7: pat = 7'b0000111;
      8: pat = 7'b1111111;
      9: pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic drive_exp(input logic [3:0] g, input logic s,
                           input logic [6:0] lo, input logic [6:0] hi);
    exp_t e;
    exp_t r;
    gray_code    = g;
    show_decades = s;
    e.g = g; e.s = s; e.lo = lo; e.hi = hi;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 2) begin
      r = q.pop_front();
      check($sformatf("lo g=%b s=%b", r.g, r.s), disp_lo, r.lo);
      check($sformatf("hi g=%b s=%b", r.g, r.s), disp_hi, r.hi);
    end
  endtask

  task automatic drive(input logic [3:0] g, input logic s);
    drive_exp(g, s, ~pat(g, s), pat(g, s));
  endtask

  task automatic flush();
    exp_t r;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      r = q.pop_front();
      check($sformatf("lo flush g=%b s=%b", r.g, r.s), disp_lo, r.lo);
      check($sformatf("hi flush g=%b s=%b", r.g, r.s), disp_hi, r.hi);
    end
  endtask

  initial begin
    // Reset takes effect before any clock edge
    gray_code = 4'b0101;
    show_decades = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("reset_immediate_lo", disp_lo, 7'b1111111);
    check("reset_immediate_hi", disp_hi, 7'b0000000);
    @(posedge clk); #1;
    check("reset_held_lo", disp_lo, 7'b1111111);
    check("reset_held_hi", disp_hi, 7'b0000000);
    rst = 1'b0;

    drive_exp(4'b0000, 1'b0, 7'b1000000, 7'b0111111);

    // Units sweep with spot values written out
    for (int i = 0; i < 16; i++) begin
      case (i)
        1:       drive_exp(4'(i), 1'b0, 7'b1111001, 7'b0000110);
        6:       drive_exp(4'(i), 1'b0, 7'b0011001, 7'b1100110);
        13:      drive_exp(4'(i), 1'b0, 7'b0010000, 7'b1101111);
        15:      drive_exp(4'(i), 1'b0, 7'b1000000, 7'b0111111);
        8:       drive_exp(4'(i), 1'b0, 7'b0010010, 7'b1101101);
        default: drive(4'(i), 1'b0);
      endcase
    end

    // Tens sweep: codes for v>=10 show "1", others "0"
    for (int i = 0; i < 16; i++) begin
      if (i == 15 || i == 14 || i == 10 || i == 11 || i == 9 || i == 8)
        drive_exp(4'(i), 1'b1, 7'b1111001, 7'b0000110);
      else
        drive_exp(4'(i), 1'b1, 7'b1000000, 7'b0111111);
    end

    // Select toggle on held value 12
    drive_exp(4'b1010, 1'b0, 7'b0100100, 7'b1011011);
    drive_exp(4'b1010, 1'b0, 7'b0100100, 7'b1011011);
    drive_exp(4'b1010, 1'b1, 7'b1111001, 7'b0000110);
    drive_exp(4'b1010, 1'b1, 7'b1111001, 7'b0000110);

    // Active-high instance, value 7
    drive_exp(4'b0100, 1'b0, 7'b1111000, 7'b0000111);

    // Per-cycle changes including simultaneous gray/select updates
    for (int i = 0; i < 30; i++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    flush();

    // Reset mid-cycle, then recovery
    drive(4'b0110, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midreset_lo", disp_lo, 7'b1111111);
    check("midreset_hi", disp_hi, 7'b0000000);
    q.delete();
    @(posedge clk); #1;
    check("midreset_edge_lo", disp_lo, 7'b1111111);
    rst = 1'b0;
    drive(4'b1101, 1'b0);
    drive(4'b1111, 1'b1);
    drive(4'b0111, 1'b0);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_seg_decoder.md
Name: gray_seg_decoder

Overview:
- Converts a 4-bit Gray-code input to binary (0–15).
- Splits the value into decimal units and tens digits.
- Drives one 7-segment digit with either the units digit or the tens digit, selected by show_decades.
- Sits between board switches and a single 7-segment display. Fully synchronous, with a registered two-stage path.

Parameters:
- SEG_ACTIVE_LOW, default 1: 1 means a segment is lit when its bit is 0 (common-anode); 0 means a segment is lit when its bit is 1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- gray_code  input  4  Gray-coded value, bit 3 is MSB
- show_decades  input  1  0 selects the units digit, 1 selects the tens digit
- display_code  output  7  segment drive; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- While rst=1:
  - All internal registers clear to 0.
  - display_code shows all segments off: 7'b1111111 when SEG_ACTIVE_LOW=1, 7'b0000000 when SEG_ACTIVE_LOW=0.
  - Reset asserts immediately, without waiting for a clock edge.
- Stage 1, every rising edge after reset:
  - gray_code and show_decades are registered.
  - Registered Gray is converted to binary: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
- Stage 2, every rising edge: display_code is registered from the stage-1 result.
- Latency: an input change present before edge N appears on display_code after edge N+1 (2 cycles).
- No handshake; throughput is one value per cycle.
- Digit split, for binary value v (0–15):
  - units = v mod 10.
  - tens = 1 if v ≥ 10, else 0.
- Digit select:
  - show_decades=0 displays units.
  - show_decades=1 displays tens; for v<10 the digit shown is "0" (no blanking).
- Segment patterns, active-high form {g,f,e,d,c,b,a}:
  - 0 → 0111111
  - 1 → 0000110
  - 2 → 1011011
  - 3 → 1001111
  - 4 → 1100110
  - 5 → 1101101
  - 6 → 1111101
  - 7 → 0000111
  - 8 → 1111111
  - 9 → 1101111
- Output polarity: when SEG_ACTIVE_LOW=1, display_code is the bitwise inverse of the pattern above.
- Coverage: all 16 Gray inputs are legal. No digit value outside 0–9 can occur.
- Defensive default: the decoder's default branch drives all segments off.
- Boundary and ordering rules:
  - show_decades toggling with a constant gray_code changes the output 2 cycles later.
  - A simultaneous change of gray_code and show_decades is treated as one new sample.
  - Reset mid-operation forces the off pattern. Valid output resumes 2 edges after rst deasserts.
  - X/Z on the inputs is not filtered.

Test Plan:
- Reset: assert rst with any inputs → display_code = 7'b1111111 immediately. Deassert, apply gray 0000 with show_decades=0 → 7'b1000000 two edges later.
- Units sweep (show_decades=0, SEG_ACTIVE_LOW=1): apply all 16 Gray codes 0000..1111 in order. Required outputs:
  - gray 0001 (v=1) → 1111001
  - gray 0110 (v=4) → 0011001
  - gray 1101 (v=9) → 0010000
  - gray 1111 (v=10) → 1000000
  - gray 1000 (v=15) → 0010010
- Tens sweep (show_decades=1): repeat the 16-code sweep.
  - gray 0000..1101 (v=0..9) → 1000000.
  - gray 1111, 1110, 1010, 1011, 1001, 1000 (v=10..15) → 1111001.
- Select toggle: hold gray 1010 (v=12).
  - show_decades 0 → 0100100 ("2").
  - Toggle to 1 → 1111001 ("1") exactly 2 cycles later.
- Latency and throughput: change gray_code every cycle. Each output equals the decoded input from 2 cycles earlier; no value is dropped.
- Polarity: SEG_ACTIVE_LOW=0 with gray 0100 (v=7), show_decades=0 → 0000111; under reset → 0000000.
